// File: rtl/bht_update_queue.sv
// ---------------------------------------------------------------------------
// bht_update_queue
//
// Commit-side writer for the local branch history table. Retire hands over
// up to two resolved conditional-branch outcomes per cycle, in program order
// (cm0 older than cm1). They are buffered in a circular FIFO. The FIFO drains
// one outcome per cycle onto the history table's single write port.
//
// Same-index updates are never merged. Each buffered outcome produces its
// own shift-in pulse, in strict push order.
//
// Ports:
//   clock              core clock; all state updates on the rising edge
//   reset              synchronous active-high reset; discards pending entries
//   cm0_valid_i        older retiring branch valid
//   cm0_index_i        older branch history-table index
//   cm0_brdir_i        older branch direction (1 = taken)
//   cm1_valid_i        younger retiring branch valid
//   cm1_index_i        younger branch history-table index
//   cm1_brdir_i        younger branch direction
//   cm_ready_o         two free slots available; pushes are ignored otherwise
//   wt_stall_i         history-table write port busy; holds the head entry
//   bht_wt_index_o     history-table write index (holds between updates)
//   bht_cm_brdir_o     direction to shift in (holds between updates)
//   bht_cm_brdir_se_o  shift-in enable, one-cycle pulse per update
//   count_o            current FIFO occupancy
//   idle_o             FIFO empty and no update pulse on the output
// ---------------------------------------------------------------------------
module bht_update_queue #(
   parameter int unsigned IDXW  = 10,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     cm0_valid_i,
   input  logic [IDXW-1:0]          cm0_index_i,
   input  logic                     cm0_brdir_i,
   input  logic                     cm1_valid_i,
   input  logic [IDXW-1:0]          cm1_index_i,
   input  logic                     cm1_brdir_i,
   output logic                     cm_ready_o,
   input  logic                     wt_stall_i,
   output logic [IDXW-1:0]          bht_wt_index_o,
   output logic                     bht_cm_brdir_o,
   output logic                     bht_cm_brdir_se_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     idle_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   // Two slots free <=> count <= DEPTH-2.
   localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

   // Entry storage. It is not reset: only the pointers and count define
   // which slots hold live entries.
   logic [IDXW-1:0] idx_mem [DEPTH];
   logic            dir_mem [DEPTH];

   logic [PW-1:0]   wptr_q;
   logic [PW-1:0]   rptr_q;
   logic [CW-1:0]   count_q;
   logic [PW-1:0]   wptr_d;
   logic [PW-1:0]   rptr_d;
   logic [CW-1:0]   count_d;

   logic            ready;
   logic            push0;
   logic            push1;
   logic            pop;
   logic [PW-1:0]   wslot1;
   logic [CW-1:0]   push_cnt;

   logic [IDXW-1:0] out_idx_q;
   logic            out_dir_q;
   logic            out_se_q;

   // -------------------------------------------------------------------
   // Push / pop decisions and next-state pointers
   // -------------------------------------------------------------------
   always_comb begin
      ready    = (count_q <= READY_MAX);
      push0    = ready & cm0_valid_i;
      push1    = ready & cm1_valid_i;
      // Pop uses the pre-push count. A freshly pushed entry therefore cannot
      // leave in the same cycle, so there is no bypass path.
      pop      = (count_q != '0) & ~wt_stall_i;
      // cm1 lands right after cm0 when both push, else at the write pointer.
      wslot1   = push0 ? (wptr_q + PW'(1)) : wptr_q;
      push_cnt = CW'(push0) + CW'(push1);
      count_d  = count_q + push_cnt - CW'(pop);
      wptr_d   = wptr_q + PW'(push_cnt);
      rptr_d   = rptr_q + PW'(pop);
   end

   // -------------------------------------------------------------------
   // Pointer, count and output registers
   // -------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         out_idx_q <= '0;
         out_dir_q <= 1'b0;
         out_se_q  <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         out_se_q <= pop;
         if (pop) begin
            out_idx_q <= idx_mem[rptr_q];
            out_dir_q <= dir_mem[rptr_q];
         end
      end
   end

   // -------------------------------------------------------------------
   // Entry storage writes
   // -------------------------------------------------------------------
   // Pushes only target free slots (ready guarantees two of them). The read
   // of the head slot above therefore never collides with a write.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (push0) begin
            idx_mem[wptr_q] <= cm0_index_i;
            dir_mem[wptr_q] <= cm0_brdir_i;
         end
         if (push1) begin
            idx_mem[wslot1] <= cm1_index_i;
            dir_mem[wslot1] <= cm1_brdir_i;
         end
      end
   end

   // -------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------
   assign cm_ready_o        = ready;
   assign bht_wt_index_o    = out_idx_q;
   assign bht_cm_brdir_o    = out_dir_q;
   assign bht_cm_brdir_se_o = out_se_q;
   assign count_o           = count_q;
   assign idle_o            = (count_q == '0) & ~out_se_q;

endmodule

// File: tb/tb_bht_update_queue.sv
// ---------------------------------------------------------------------------
// tb_bht_update_queue
//
// Directed bench for bht_update_queue (IDXW = 10, DEPTH = 8).
//
// Part 1 is a vector table. Each record holds the inputs for one cycle and
// the hand-computed outputs expected after the following rising edge.
//
// Part 2 is a hand-written wrap sequence. It issues continuous dual pushes
// while the queue drains one entry per cycle, and checks each emitted entry
// against the accepted push order.
// ---------------------------------------------------------------------------
module tb_bht_update_queue;

   localparam int unsigned IDXW  = 10;
   localparam int unsigned DEPTH = 8;

   logic            clock;
   logic            reset;
   logic            cm0_valid_i;
   logic [IDXW-1:0] cm0_index_i;
   logic            cm0_brdir_i;
   logic            cm1_valid_i;
   logic [IDXW-1:0] cm1_index_i;
   logic            cm1_brdir_i;
   logic            cm_ready_o;
   logic            wt_stall_i;
   logic [IDXW-1:0] bht_wt_index_o;
   logic            bht_cm_brdir_o;
   logic            bht_cm_brdir_se_o;
   logic [3:0]      count_o;
   logic            idle_o;

   bht_update_queue #(
      .IDXW  (IDXW),
      .DEPTH (DEPTH)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .cm0_valid_i       (cm0_valid_i),
      .cm0_index_i       (cm0_index_i),
      .cm0_brdir_i       (cm0_brdir_i),
      .cm1_valid_i       (cm1_valid_i),
      .cm1_index_i       (cm1_index_i),
      .cm1_brdir_i       (cm1_brdir_i),
      .cm_ready_o        (cm_ready_o),
      .wt_stall_i        (wt_stall_i),
      .bht_wt_index_o    (bht_wt_index_o),
      .bht_cm_brdir_o    (bht_cm_brdir_o),
      .bht_cm_brdir_se_o (bht_cm_brdir_se_o),
      .count_o           (count_o),
      .idle_o            (idle_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic            rst;
      logic            v0;
      logic [IDXW-1:0] i0;
      logic            d0;
      logic            v1;
      logic [IDXW-1:0] i1;
      logic            d1;
      logic            stall;
      logic            e_se;
      logic [IDXW-1:0] e_idx;
      logic            e_dir;
      logic [3:0]      e_cnt;
      logic            e_rdy;
      logic            e_idle;
   } vec_t;

   typedef struct {
      logic [IDXW-1:0] idx;
      logic            dir;
   } ent_t;

   vec_t vecs[$];
   ent_t sb[$];
   int   n_cmp;
   int   n_bad;

   function automatic vec_t mk(input int rst, input int v0, input int i0, input int d0,
                               input int v1, input int i1, input int d1, input int stall,
                               input int se, input int idx, input int dir, input int cnt,
                               input int rdy, input int idle);
      vec_t r;
      r.rst    = 1'(rst);
      r.v0     = 1'(v0);
      r.i0     = IDXW'(i0);
      r.d0     = 1'(d0);
      r.v1     = 1'(v1);
      r.i1     = IDXW'(i1);
      r.d1     = 1'(d1);
      r.stall  = 1'(stall);
      r.e_se   = 1'(se);
      r.e_idx  = IDXW'(idx);
      r.e_dir  = 1'(dir);
      r.e_cnt  = 4'(cnt);
      r.e_rdy  = 1'(rdy);
      r.e_idle = 1'(idle);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      int   m_cnt;
      int   seq;
      logic m_rdy;
      logic m_pop;
      ent_t exp_e;
      ent_t e;

      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      cm0_valid_i = 1'b0; cm0_index_i = '0; cm0_brdir_i = 1'b0;
      cm1_valid_i = 1'b0; cm1_index_i = '0; cm1_brdir_i = 1'b0;
      wt_stall_i  = 1'b0;

      //           rst v0 i0     d0 v1 i1     d1 st | se idx    dir cnt rdy idle
      // reset, single push, one-cycle se pulse
      vecs.push_back(mk(1, 0,0,0,      0,0,0,      0,  0,'h000,0, 0,1,1));
      vecs.push_back(mk(0, 1,'h155,1,  0,0,0,      0,  0,'h000,0, 1,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  1,'h155,1, 0,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  0,'h155,1, 0,1,1));
      // dual push then single push, consecutive ordered drain
      vecs.push_back(mk(0, 1,'h010,1,  1,'h020,0,  0,  0,'h155,1, 2,1,0));
      vecs.push_back(mk(0, 1,'h030,1,  0,0,0,      0,  1,'h010,1, 2,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  1,'h020,0, 1,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  1,'h030,1, 0,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  0,'h030,1, 0,1,1));
      // same index back-to-back, no merge
      vecs.push_back(mk(0, 1,'h3FF,1,  0,0,0,      0,  0,'h030,1, 1,1,0));
      vecs.push_back(mk(0, 1,'h3FF,0,  0,0,0,      0,  1,'h3FF,1, 1,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  1,'h3FF,0, 0,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  0,'h3FF,0, 0,1,1));
      vecs.push_back(mk(0, 1,'h3FF,0,  1,'h3FF,1,  0,  0,'h3FF,0, 2,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  1,'h3FF,0, 1,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  1,'h3FF,1, 0,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  0,'h3FF,1, 0,1,1));
      // stall with dual pushes until full; pushes while not ready ignored
      vecs.push_back(mk(0, 1,'h001,1,  1,'h002,0,  1,  0,'h3FF,1, 2,1,0));
      vecs.push_back(mk(0, 1,'h003,1,  1,'h004,0,  1,  0,'h3FF,1, 4,1,0));
      vecs.push_back(mk(0, 1,'h005,0,  1,'h006,1,  1,  0,'h3FF,1, 6,1,0));
      vecs.push_back(mk(0, 1,'h007,1,  1,'h008,1,  1,  0,'h3FF,1, 8,0,0));
      vecs.push_back(mk(0, 1,'h00A,0,  1,'h00B,0,  1,  0,'h3FF,1, 8,0,0));
      vecs.push_back(mk(0, 1,'h00C,1,  0,0,0,      1,  0,'h3FF,1, 8,0,0));
      // release: drain in push order; count 7 still not ready
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  1,'h001,1, 7,0,0));
      vecs.push_back(mk(0, 1,'h0EE,1,  1,'h0EF,1,  0,  1,'h002,0, 6,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  1,'h003,1, 5,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  1,'h004,0, 4,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      1,  0,'h004,0, 4,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  1,'h005,0, 3,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  1,'h006,1, 2,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  1,'h007,1, 1,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  1,'h008,1, 0,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  0,'h008,1, 0,1,1));
      // reset mid-drain at count 5 with se high, then normal push
      vecs.push_back(mk(0, 1,'h011,1,  1,'h012,0,  0,  0,'h008,1, 2,1,0));
      vecs.push_back(mk(0, 1,'h013,1,  1,'h014,1,  0,  1,'h011,1, 3,1,0));
      vecs.push_back(mk(0, 1,'h015,0,  1,'h016,0,  0,  1,'h012,0, 4,1,0));
      vecs.push_back(mk(0, 1,'h017,1,  1,'h018,0,  0,  1,'h013,1, 5,1,0));
      vecs.push_back(mk(1, 1,'h019,1,  1,'h01A,1,  0,  0,'h000,0, 0,1,1));
      vecs.push_back(mk(0, 0,0,0,      1,'h2AB,0,  0,  0,'h000,0, 1,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  1,'h2AB,0, 0,1,0));
      vecs.push_back(mk(0, 0,0,0,      0,0,0,      0,  0,'h2AB,0, 0,1,1));

      foreach (vecs[k]) begin
         reset       = vecs[k].rst;
         cm0_valid_i = vecs[k].v0;
         cm0_index_i = vecs[k].i0;
         cm0_brdir_i = vecs[k].d0;
         cm1_valid_i = vecs[k].v1;
         cm1_index_i = vecs[k].i1;
         cm1_brdir_i = vecs[k].d1;
         wt_stall_i  = vecs[k].stall;
         @(posedge clock);
         #1;
         check($sformatf("vec%0d se", k),    32'(bht_cm_brdir_se_o), 32'(vecs[k].e_se));
         check($sformatf("vec%0d index", k), 32'(bht_wt_index_o),    32'(vecs[k].e_idx));
         check($sformatf("vec%0d brdir", k), 32'(bht_cm_brdir_o),    32'(vecs[k].e_dir));
         check($sformatf("vec%0d count", k), 32'(count_o),           32'(vecs[k].e_cnt));
         check($sformatf("vec%0d ready", k), 32'(cm_ready_o),        32'(vecs[k].e_rdy));
         check($sformatf("vec%0d idle", k),  32'(idle_o),            32'(vecs[k].e_idle));
      end

      // Wrap sequence: reset, then an odd single push so that later pairs
      // straddle the DEPTH-1 -> 0 boundary. After that come dual pushes
      // every cycle with one pop per cycle, then a drain.
      reset = 1'b1;
      cm0_valid_i = 1'b0;
      cm1_valid_i = 1'b0;
      wt_stall_i  = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("wrap reset count", 32'(count_o), 32'd0);
      m_cnt = 0;
      seq   = 0;
      for (int cyc = 0; cyc < 52; cyc++) begin
         cm0_valid_i = (cyc < 42);
         cm1_valid_i = (cyc < 42) && (cyc != 0);
         cm0_index_i = IDXW'(10'h100 + seq);
         cm0_brdir_i = seq[0] ^ seq[2];
         cm1_index_i = IDXW'(10'h100 + seq + 1);
         cm1_brdir_i = ~(seq[1]);
         m_rdy = (m_cnt <= DEPTH - 2);
         check($sformatf("wrap%0d ready", cyc), 32'(cm_ready_o), 32'(m_rdy));
         m_pop = (m_cnt > 0);
         if (m_pop) exp_e = sb.pop_front();
         if (m_rdy && cm0_valid_i) begin
            e.idx = cm0_index_i; e.dir = cm0_brdir_i; sb.push_back(e); m_cnt++;
         end
         if (m_rdy && cm1_valid_i) begin
            e.idx = cm1_index_i; e.dir = cm1_brdir_i; sb.push_back(e); m_cnt++;
         end
         if (m_pop) m_cnt--;
         seq = seq + 2;
         @(posedge clock);
         #1;
         check($sformatf("wrap%0d se", cyc), 32'(bht_cm_brdir_se_o), 32'(m_pop));
         if (m_pop) begin
            check($sformatf("wrap%0d index", cyc), 32'(bht_wt_index_o), 32'(exp_e.idx));
            check($sformatf("wrap%0d brdir", cyc), 32'(bht_cm_brdir_o), 32'(exp_e.dir));
         end
         check($sformatf("wrap%0d count", cyc), 32'(count_o), 32'(m_cnt));
      end
      cm0_valid_i = 1'b0;
      cm1_valid_i = 1'b0;
      check("wrap final idle", 32'(idle_o), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
